// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared JK command codes, lock FSM states and next-state helper
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   function automatic logic jk_next(input logic q, input logic [1:0] jk);
      logic d;
      case (jk)
         JK_CLR:  d = 1'b0;
         JK_SET:  d = 1'b1;
         JK_TGL:  d = ~q;
         default: d = q;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with enable and registered complement
module jk_cell
   import jk_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] jk,
   output logic       q,
   output logic       qb
);

   logic d;

   always_comb d = en ? jk_next(q, jk) : q;

   // qb is its own flop so both outputs come straight from registers
   always_ff @(posedge clk) begin
      if (rst) begin
         q  <= 1'b0;
         qb <= 1'b1;
      end else begin
         q  <= d;
         qb <= ~d;
      end
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter with timed lock sharing one JK flag bank
module jk_bank_arbiter
   import jk_pkg::*;
#(
   parameter  int NREQ     = 4,
   parameter  int NBITS    = 8,
   parameter  int LOCK_MAX = 16,
   localparam int RW       = $clog2(NREQ),
   localparam int IW       = $clog2(NBITS),
   localparam int CW       = $clog2(LOCK_MAX)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [2*NREQ-1:0]  op,
   input  logic [IW*NREQ-1:0] idx,
   output logic [NREQ-1:0]    gnt,
   output logic [NBITS-1:0]   q,
   output logic [NBITS-1:0]   qb,
   output logic               locked,
   output logic [RW-1:0]      owner,
   output logic               lock_timeout
);

   state_t        state, state_nxt;
   logic [RW-1:0] ptr, ptr_nxt, owner_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          tmo_nxt;
   logic [RW-1:0] win, cand;
   logic          win_vld;
   logic [1:0]    win_op;
   logic [IW-1:0] win_idx;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      cnt_nxt   = cnt;
      tmo_nxt   = 1'b0;
      win       = '0;
      win_vld   = 1'b0;
      cand      = '0;
      gnt       = '0;
      if (state == ST_IDLE) begin
         for (int i = 0; i < NREQ; i++) begin
            cand = ptr + RW'(i);
            if (!win_vld && req[cand]) begin
               win     = cand;
               win_vld = 1'b1;
            end
         end
         if (win_vld) begin
            ptr_nxt = win + 1'b1;
            if (lock[win]) begin
               state_nxt = ST_LOCKED;
               owner_nxt = win;
               cnt_nxt   = '0;
            end
         end
      end else begin
         win     = owner;
         win_vld = req[owner];
         cnt_nxt = cnt + 1'b1;
         // voluntary release wins over timeout; either way the owner's command still lands
         if (!lock[owner]) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = owner + 1'b1;
         end else if (cnt == CW'(LOCK_MAX - 1)) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = owner + 1'b1;
            tmo_nxt   = 1'b1;
         end
      end
      if (rst) win_vld = 1'b0;
      if (win_vld) gnt[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         owner        <= '0;
         cnt          <= '0;
         lock_timeout <= 1'b0;
      end else begin
         state        <= state_nxt;
         ptr          <= ptr_nxt;
         owner        <= owner_nxt;
         cnt          <= cnt_nxt;
         lock_timeout <= tmo_nxt;
      end
   end

   assign locked  = (state == ST_LOCKED);
   assign win_op  = op[win*2 +: 2];
   assign win_idx = idx[win*IW +: IW];

   for (genvar b = 0; b < NBITS; b++) begin : g_bank
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .en  (win_vld && (win_idx == IW'(b))),
         .jk  (win_op),
         .q   (q[b]),
         .qb  (qb[b])
      );
   end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - randomized and directed checks of jk_bank_arbiter against a behavioural model
module tb_jk_bank_arbiter;

   localparam int NREQ     = 4;
   localparam int NBITS    = 8;
   localparam int LOCK_MAX = 16;
   localparam int RW       = $clog2(NREQ);
   localparam int IW       = $clog2(NBITS);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req, lock, gnt;
   logic [2*NREQ-1:0]    op;
   logic [IW*NREQ-1:0]   idx;
   logic [NBITS-1:0]     q, qb;
   logic                 locked, lock_timeout;
   logic [RW-1:0]        owner;

   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .op(op), .idx(idx),
      .gnt(gnt), .q(q), .qb(qb), .locked(locked), .owner(owner),
      .lock_timeout(lock_timeout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [NREQ-1:0]  req_r, lock_r;
   logic [1:0]       op_a  [NREQ];
   logic [IW-1:0]    idx_a [NREQ];

   logic [NBITS-1:0] mq;
   int               m_locked, m_owner, m_ptr, m_held, m_tmo;
   int               last_w;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      req  = req_r;
      lock = lock_r;
      for (int r = 0; r < NREQ; r++) begin
         op[2*r +: 2]   = op_a[r];
         idx[IW*r +: IW] = idx_a[r];
      end
   endtask

   // the requester that should be served this cycle, or -1
   function automatic int exp_winner();
      if (rst) return -1;
      if (m_locked != 0) return req_r[m_owner] ? m_owner : -1;
      for (int i = 0; i < NREQ; i++)
         if (req_r[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
      return -1;
   endfunction

   task automatic model_edge(input int w);
      if (rst) begin
         mq = '0; m_locked = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_tmo = 0;
         return;
      end
      m_tmo = 0;
      if (w >= 0) begin
         case (op_a[w])
            2'b01:   mq[idx_a[w]] = 1'b0;
            2'b10:   mq[idx_a[w]] = 1'b1;
            2'b11:   mq[idx_a[w]] = ~mq[idx_a[w]];
            default: ;
         endcase
      end
      if (m_locked == 0) begin
         if (w >= 0) begin
            m_ptr = (w + 1) % NREQ;
            if (lock_r[w]) begin
               m_locked = 1; m_owner = w; m_held = 0;
            end
         end
      end else begin
         m_held++;
         if (!lock_r[m_owner]) begin
            m_locked = 0; m_ptr = (m_owner + 1) % NREQ;
         end else if (m_held == LOCK_MAX) begin
            m_locked = 0; m_ptr = (m_owner + 1) % NREQ; m_tmo = 1;
         end
      end
   endtask

   task automatic cycle();
      int w;
      logic [NBITS-1:0] eqb;
      drive();
      w = exp_winner();
      last_w = w;
      eqb = ~mq;
      #3;
      check("gnt", gnt, (w >= 0) ? (32'd1 << w) : 32'd0);
      check("q", q, mq);
      check("qb", qb, eqb);
      check("locked", locked, m_locked);
      check("owner", owner, m_owner);
      check("lock_timeout", lock_timeout, m_tmo);
      @(posedge clk);
      model_edge(w);
      #1;
   endtask

   task automatic clear_inputs();
      req_r = '0; lock_r = '0;
      for (int r = 0; r < NREQ; r++) begin
         op_a[r] = 2'b00; idx_a[r] = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      drive();
      @(posedge clk);
      #1;
      model_edge(-1);

      // reset state, then a single requester sets and toggles bit 3
      do_reset();
      req_r[0] = 1'b1; op_a[0] = 2'b10; idx_a[0] = 3'd3;
      cycle();
      check("tp1_q_set", q, 32'h08);
      check("tp1_qb_set", qb, 32'hF7);
      op_a[0] = 2'b11;
      cycle();
      check("tp1_q_tgl", q, 32'h00);

      // round robin from reset
      do_reset();
      for (int r = 0; r < NREQ; r++) begin
         req_r[r] = 1'b1; op_a[r] = 2'b10; idx_a[r] = IW'(r);
      end
      repeat (5) cycle();
      check("tp2_q", q, 32'h0F);

      // lock exclusivity and handoff after release
      do_reset();
      req_r[2] = 1'b1; lock_r[2] = 1'b1; op_a[2] = 2'b11; idx_a[2] = 3'd5;
      cycle();
      req_r[0] = 1'b1; req_r[1] = 1'b1; req_r[3] = 1'b1;
      repeat (5) cycle();
      check("tp3_locked", locked, 32'd1);
      check("tp3_owner", owner, 32'd2);
      lock_r[2] = 1'b0;
      cycle();
      req_r[2] = 1'b0;
      #3;
      check("tp3_next_gnt", gnt, 32'b1000);
      #1;
      cycle();

      // timeout with a waiting requester
      do_reset();
      req_r[1] = 1'b1; lock_r[1] = 1'b1; op_a[1] = 2'b11; idx_a[1] = 3'd0;
      req_r[2] = 1'b1; op_a[2] = 2'b10; idx_a[2] = 3'd7;
      repeat (LOCK_MAX + 1) cycle();
      check("tp4_timeout", lock_timeout, 32'd1);
      check("tp4_unlocked", locked, 32'd0);
      lock_r[1] = 1'b0;
      cycle();
      check("tp4_q7", q[7], 32'd1);

      // lock held without requests, then a hold command
      do_reset();
      req_r[0] = 1'b1; lock_r[0] = 1'b1; op_a[0] = 2'b00;
      cycle();
      req_r[0] = 1'b0;
      repeat (5) cycle();
      check("tp5_q", q, 32'h00);
      req_r[0] = 1'b1;
      cycle();
      check("tp5_q_hold", q, 32'h00);

      // reset while locked with q = A5
      do_reset();
      req_r[0] = 1'b1; op_a[0] = 2'b10;
      for (int k = 0; k < 4; k++) begin
         idx_a[0] = (k == 0) ? 3'd0 : (k == 1) ? 3'd2 : (k == 2) ? 3'd5 : 3'd7;
         cycle();
      end
      req_r[0] = 1'b0;
      req_r[1] = 1'b1; lock_r[1] = 1'b1; op_a[1] = 2'b00; idx_a[1] = 3'd1;
      cycle();
      check("tp6_q_a5", q, 32'hA5);
      op_a[1] = 2'b11;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("tp6_q", q, 32'h00);
      check("tp6_qb", qb, 32'hFF);
      check("tp6_locked", locked, 32'd0);
      req_r[0] = 1'b1; lock_r[1] = 1'b0;
      cycle();

      // randomized traffic with sticky locks and occasional reset
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (last_w == r || !req_r[r]) begin
               if (last_w == r || ($urandom % 3) == 0) begin
                  req_r[r] = 1'($urandom % 2);
                  op_a[r]  = 2'($urandom % 4);
                  idx_a[r] = IW'($urandom % NBITS);
               end
            end
            if (($urandom % 20) == 0) lock_r[r] = ~lock_r[r];
         end
         rst = (($urandom % 150) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of NBITS JK flip-flops between NREQ requesters.
- Each requester presents a 2-bit JK command and a target bit index. A round-robin arbiter grants one command per cycle, and the granted command is applied to the bank at the next clock edge.
- A requester may hold a lock for an atomic multi-cycle sequence, bounded by a timeout.
- Sits between control engines and the shared JK flag register.

Parameters:
- NREQ, 4, number of requesters (power of two, >=2)
- NBITS, 8, number of JK flip-flops in the bank (power of two, >=2)
- LOCK_MAX, 16, maximum cycles a lock may be held before forced release (>=2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester command valid
- lock  input  NREQ  per-requester lock request; sampled only for the granted or owning requester
- op  input  2*NREQ  JK command per requester, slice r = op[2r+1:2r], {J,K}
- idx  input  log2(NBITS)*NREQ  target bit per requester, slice r
- gnt  output  NREQ  one-hot grant, combinational; command accepted at the edge where gnt[r]=1
- q  output  NBITS  bank state, registered
- qb  output  NBITS  ~q, registered
- locked  output  1  registered, 1 while state is LOCKED
- owner  output  log2(NREQ)  registered current or last lock owner
- lock_timeout  output  1  registered single-cycle pulse on forced release

Behaviour:
- JK encoding {J,K}:
  - 00: hold
  - 01: clear to 0
  - 10: set to 1
  - 11: toggle
- Only bit q[idx of winner] is affected; all other bits hold.
- Reset (rst=1 at edge):
  - q=0, qb=all ones
  - state=IDLE, ptr=0, owner=0, locked=0, lock_timeout=0, lock counter=0
  - No command is applied in that cycle; gnt is forced to 0 while rst=1.
- State IDLE:
  - Winner = first r with req[r]=1, searching ptr, ptr+1, ... mod NREQ.
  - gnt = onehot(winner), or 0 if no req.
  - At the edge, if a winner exists:
    - Apply its op.
    - ptr <= winner+1 (mod NREQ).
    - If lock[winner]=1: state<=LOCKED, owner<=winner, counter<=0.
- State LOCKED:
  - gnt[owner] = req[owner]; all other grants are 0 regardless of their req.
  - At each edge, if req[owner], apply its op. Lock without req holds the bank idle.
  - counter increments every LOCKED cycle.
  - If lock[owner]=0 at the edge: state<=IDLE, ptr<=owner+1. A command presented in that same cycle is still applied.
  - Else if counter==LOCK_MAX-1: state<=IDLE, ptr<=owner+1, lock_timeout<=1 for one cycle. Any granted command in that cycle is applied. The owner competes normally afterwards.
- Latency: command accepted in cycle t is visible on q/qb after edge t, i.e. in cycle t+1.
- Latency: two commands to the same bit in consecutive cycles compose (e.g. toggle then toggle returns to the original value).
- Fairness: with all requesters continuously active and unlocked, each receives exactly one grant per NREQ cycles.
- Requesters must hold req/op/idx stable until granted. Unaccepted commands carry no state.
- Width rule: idx is log2(NBITS) bits, so every value is in range; no out-of-range case exists.
- rst asserted mid-lock: immediate return to IDLE with reset values; the pending command is dropped.

Decomposition:
- Shared package jk_pkg:
  - JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11
  - state encoding IDLE/LOCKED
- Sub-module jk_cell:
  - One JK flip-flop with sync active-high rst and enable.
  - Ports clk, rst, en, jk[1:0], q, qb.
  - Instantiated NBITS times; en = grant valid and idx==bit.
- Arbiter, lock FSM and timeout counter live in the top module.

Test Plan:
- Reset then single requester: req[0]=1, idx0=3, op0=10 -> gnt=0001; after the edge q=0x08, qb=0xF7; op0=11 next cycle -> q=0x00.
- Round-robin: all four req=1, op=10, idx r=r, from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001; q=0x0F after 4 edges.
- Lock exclusivity: req2+lock2 with op=11 idx=5, others requesting -> gnt=0100 for every locked cycle; locked=1, owner=2; q[5] toggles each cycle. Drop lock2 -> next grant goes to requester 3.
- Timeout: lock1=1, req1=1 held with LOCK_MAX=16 -> lock_timeout pulses exactly once, 16 cycles after lock entry; locked=0 the next cycle; pending requester 2 is granted.
- Hold and lock-without-req: owner asserts lock but req=0 for 5 cycles -> gnt=0 and q unchanged; op=00 granted -> q unchanged.
- Reset mid-lock: rst=1 while locked with q=0xA5 -> the next cycle has q=0x00, qb=0xFF, locked=0, ptr=0, and the command applied in the rst cycle is dropped.
